// File: rtl/clk_div_bank.sv
// Bank of NUM_CH glitch-free programmable clock dividers with double-buffered divisors.
// Optional CLK_DIV_SYNC_EN: a sync pulse re-phases every running channel and applies pending divisors.

module clk_div_lane #(
  parameter int             CNT_W    = 16,
  parameter logic [CNT_W-1:0] DIV_INIT = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sync,
  input  logic             wr_hit,
  input  logic [CNT_W-1:0] wr_div,
  output logic             div_clk,
  output logic             tick,
  output logic             upd_pend
);

  typedef enum logic {ST_STOP, ST_RUN} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] p_q, p_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             wrap;
  logic             apply;
  logic [CNT_W:0]   half;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_STOP;
      n_q     <= DIV_INIT;
      p_q     <= DIV_INIT;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    p_d     = p_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;

    wrap  = (state_q == ST_RUN) && (cnt_q == n_q - CNT_W'(1));
    // Divisors only change on a period boundary, so div_clk never carries a partial period.
    apply = wrap || (state_q == ST_STOP) || sync;

    if (apply) begin
      // A write landing on the boundary goes straight to N and never shows as pending.
      n_d    = wr_hit ? wr_div : (pend_q ? p_q : n_q);
      p_d    = wr_hit ? wr_div : p_q;
      pend_d = 1'b0;
    end else if (wr_hit) begin
      p_d    = wr_div;
      pend_d = 1'b1;
    end

    state_d = (en && (n_d != '0)) ? ST_RUN : ST_STOP;

    if (state_d == ST_STOP || state_q == ST_STOP || wrap || sync) cnt_d = '0;
    else                                                          cnt_d = cnt_q + CNT_W'(1);
  end

  assign half     = ({1'b0, n_q} + (CNT_W+1)'(1)) >> 1;
  assign tick     = (state_q == ST_RUN) && (cnt_q == '0);
  assign div_clk  = (state_q == ST_RUN) && ({1'b0, cnt_q} < half);
  assign upd_pend = pend_q;

endmodule

module clk_div_bank #(
  parameter int                      NUM_CH    = 3,
  parameter int                      CNT_W     = 16,
  parameter logic [NUM_CH*CNT_W-1:0] DIV_RESET = {16'd5, 16'd50, 16'd250}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              wr_en,
  input  logic [3:0]        wr_ch,
  input  logic [CNT_W-1:0]  wr_div,
  input  logic              sync,
  output logic [NUM_CH-1:0] div_clk,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] upd_pend
);

  logic sync_eff;

`ifdef CLK_DIV_SYNC_EN
  assign sync_eff = sync;
`else
  logic unused_sync;
  assign unused_sync = sync;
  assign sync_eff    = 1'b0;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Indices at or above NUM_CH never match, so such writes are dropped.
    logic wr_hit;
    assign wr_hit = wr_en && (wr_ch == 4'(i));

    clk_div_lane #(
      .CNT_W    (CNT_W),
      .DIV_INIT (DIV_RESET[i*CNT_W +: CNT_W])
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .sync     (sync_eff),
      .wr_hit   (wr_hit),
      .wr_div   (wr_div),
      .div_clk  (div_clk[i]),
      .tick     (tick[i]),
      .upd_pend (upd_pend[i])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank; t counts cycles since the first enabled edge.
module tb_clk_div_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        wr_en;
  logic [3:0]  wr_ch;
  logic [15:0] wr_div;
  logic        sync;
  logic [2:0]  div_clk;
  logic [2:0]  tick;
  logic [2:0]  upd_pend;

  int n_tests = 0;
  int n_fail  = 0;
  int t       = 0;

  clk_div_bank dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .wr_en    (wr_en),
    .wr_ch    (wr_ch),
    .wr_div   (wr_div),
    .sync     (sync),
    .div_clk  (div_clk),
    .tick     (tick),
    .upd_pend (upd_pend)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @t=%0d: got %0h expected %0h", tag, t, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic run_to(input int target);
    while (t < target) step();
  endtask

  task automatic wr(input logic [3:0] ch, input logic [15:0] val);
    wr_en  = 1'b1;
    wr_ch  = ch;
    wr_div = val;
    step();
    wr_en  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_div = '0; sync = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_div", 32'(div_clk), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_pend", 32'(upd_pend), 32'd0);

    reset = 1'b0; en = 1'b1;
    @(posedge clk); #1; t = 0;
    chk("start_tick", 32'(tick), 32'h7);
    chk("start_div", 32'(div_clk), 32'h7);

    // ch2 N=5: 1,1,1,0,0
    for (int k = 0; k < 10; k++) begin
      chk("ch2_n5_div", 32'(div_clk[2]), 32'((k % 5) < 3));
      chk("ch2_n5_tick", 32'(tick[2]), 32'((k % 5) == 0));
      step();
    end

    // ch2 -> 4 mid-period
    run_to(12);
    wr(4'd2, 16'd4);
    chk("ch2_pend_a", 32'(upd_pend[2]), 32'd1);
    step();
    chk("ch2_pend_b", 32'(upd_pend[2]), 32'd1);
    chk("ch2_tail_div", 32'(div_clk[2]), 32'd0);
    step();
    chk("ch2_pend_clr", 32'(upd_pend[2]), 32'd0);
    for (int k = 0; k < 8; k++) begin
      chk("ch2_n4_div", 32'(div_clk[2]), 32'((k % 4) < 2));
      chk("ch2_n4_tick", 32'(tick[2]), 32'((k % 4) == 0));
      step();
    end

    // ch1 bypass on the boundary cycle
    run_to(49);
    wr(4'd1, 16'd10);
    chk("ch1_byp_pend", 32'(upd_pend[1]), 32'd0);
    chk("ch1_byp_tick", 32'(tick[1]), 32'd1);
    run_to(54);
    chk("ch1_n10_hi", 32'(div_clk[1]), 32'd1);
    step();
    chk("ch1_n10_lo", 32'(div_clk[1]), 32'd0);
    run_to(59);
    chk("ch1_n10_notick", 32'(tick[1]), 32'd0);
    step();
    chk("ch1_n10_tick", 32'(tick[1]), 32'd1);

    // out-of-range channel
    wr(4'd7, 16'd3);
    chk("ch7_pend", 32'(upd_pend), 32'd0);
    run_to(63);
    chk("ch7_ch2_tick", 32'(tick[2]), 32'd1);
    run_to(70);
    chk("ch7_ch1_tick", 32'(tick[1]), 32'd1);

    // ch0 -> 0 waits for period end, then -> 1
    run_to(100);
    wr(4'd0, 16'd0);
    chk("ch0_pend", 32'(upd_pend[0]), 32'd1);
    run_to(124);
    chk("ch0_hi_end", 32'(div_clk[0]), 32'd1);
    step();
    chk("ch0_lo_start", 32'(div_clk[0]), 32'd0);
    run_to(249);
    chk("ch0_pend_late", 32'(upd_pend[0]), 32'd1);
    step();
    chk("ch0_stop_tick", 32'(tick[0]), 32'd0);
    chk("ch0_stop_div", 32'(div_clk[0]), 32'd0);
    chk("ch0_stop_pend", 32'(upd_pend[0]), 32'd0);
    run_to(255);
    chk("ch0_stay_off", 32'(div_clk[0]), 32'd0);
    run_to(260);
    wr(4'd0, 16'd1);
    chk("ch0_n1_tick", 32'(tick[0]), 32'd1);
    chk("ch0_n1_div", 32'(div_clk[0]), 32'd1);
    step();
    chk("ch0_n1_tick2", 32'(tick[0]), 32'd1);

    // sync pulse
    run_to(272);
    sync = 1'b1;
    step();
    sync = 1'b0;
`ifdef CLK_DIV_SYNC_EN
    chk("sync_all", 32'(tick), 32'h7);
    run_to(275);
    chk("sync_after", 32'(tick), 32'h1);
`else
    chk("sync_ign", 32'(tick), 32'h1);
    run_to(275);
    chk("sync_ign_after", 32'(tick), 32'h5);
`endif

    // en drop with a pending write
    run_to(276);
    wr(4'd1, 16'd7);
    chk("en_pend", 32'(upd_pend), 32'h2);
    en = 1'b0;
    step();
    chk("en_off_div", 32'(div_clk), 32'd0);
    chk("en_off_tick", 32'(tick), 32'd0);
    chk("en_off_pend", 32'(upd_pend), 32'h2);
    step();
    chk("en_off_apply", 32'(upd_pend), 32'd0);
    chk("en_off_div2", 32'(div_clk), 32'd0);
    en = 1'b1;
    step();
    chk("en_on_tick", 32'(tick), 32'h7);
    run_to(283);
    chk("ch1_n7_hi", 32'(div_clk[1]), 32'd1);
    step();
    chk("ch1_n7_lo", 32'(div_clk[1]), 32'd0);
    chk("ch2_n4_re", 32'(tick[2]), 32'd1);
    run_to(287);
    chk("n7_period", 32'(tick), 32'h3);

    // reset mid-period with a pending write
    run_to(290);
    wr(4'd2, 16'd9);
    chk("rst_pre_pend", 32'(upd_pend), 32'h4);
    reset = 1'b1;
    step();
    chk("rst_mid_div", 32'(div_clk), 32'd0);
    chk("rst_mid_tick", 32'(tick), 32'd0);
    chk("rst_mid_pend", 32'(upd_pend), 32'd0);
    step();
    chk("rst_hold_tick", 32'(tick), 32'd0);
    reset = 1'b0;
    step();
    chk("rst_restart", 32'(tick), 32'h7);
    run_to(296);
    chk("rst_n5_hi", 32'(div_clk[2]), 32'd1);
    step();
    chk("rst_n5_lo", 32'(div_clk[2]), 32'd0);
    step();
    chk("rst_n5_notick", 32'(tick[2]), 32'd0);
    step();
    chk("rst_n5_tick", 32'(tick), 32'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
